dual_fetch_queue: RTL and testbench
===================================

Name: dual_fetch_queue

Overview:
Instruction fetch unit and issue queue that sits directly upstream of the scheduling assistant and control unit. It drives sequential word reads to instruction memory and buffers the returned words in a circular FIFO. It presents the two oldest entries as instruction0 and instruction1, and retires 0, 1 or 2 entries per cycle according to the freeze1/freeze2 handshake. It replaces the fixed cache1 instruction source and adds flush/redirect support for future branch handling.

Parameters:
DEPTH, 8, queue entries; power of two, minimum 4
ADDR_W, 10, instruction memory word-address width
RESET_PC, 0, word address fetched first after reset
NOP, 32'h00000013, word driven on an instruction output whose slot is empty

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
imem_req  output  1  read request, asserted for one cycle per word
imem_addr  output  ADDR_W  word address for the current request
imem_valid  input  1  memory returns a word this cycle; arbitrary latency of 1 or more cycles, in order
imem_rdata  input  32  returned instruction word
freeze1  input  1  0 = slot 0 issued this cycle
freeze2  input  1  0 = slot 1 issued this cycle; ignored when freeze1=1
flush  input  1  discard queue and redirect fetch
flush_pc  input  ADDR_W  redirect word address
instruction0  output  32  oldest entry, or NOP when count=0
instruction1  output  32  second-oldest entry, or NOP when count<2
nothing_filled  output  1  1 when count=0
count  output  $clog2(DEPTH)+1  valid entries

Behaviour:
- Reset (async, n_rst=0), all outputs:
  - head, tail, count and outstanding = 0; pc = RESET_PC; drop = 0; state = RUN.
  - imem_req = 0; instruction0 = instruction1 = NOP; nothing_filled = 1.
- Outputs instruction0/1, nothing_filled and count are combinational from the registered queue state, so there is zero latency from queue state to outputs.
- Issue (retire) in the cycle of clk:
  - n_issue = 0 if freeze1=1.
  - Otherwise n_issue = 1 + (freeze2==0).
  - n_issue is then clamped to count; issuing from an empty slot is ignored.
  - head advances by n_issue, modulo DEPTH.
- Push:
  - A return with imem_valid=1 while drop=0 writes at tail, and tail advances by 1.
  - The same-cycle issue and push are both applied: count_next = count - n_issue + push.
  - A push always has space, because credit is reserved at request time.
- Request:
  - imem_req = 1 when state=RUN, flush=0 and count + outstanding < DEPTH.
  - imem_addr = pc; on a request, pc increments by 1 and wraps at 2^ADDR_W.
  - outstanding = +1 per request and -1 per return; both in the same cycle leaves it unchanged.
- End marker:
  - A returned word equal to 32'h00000000 while drop=0 is not pushed.
  - State goes to HALT: no further requests are made, but issue continues.
  - Later in-flight returns are discarded; their outstanding count is still decremented.
- State machine:
  - RUN -> HALT on end marker.
  - HALT -> RUN on flush.
  - RUN -> RUN on flush, with redirect.
- Flush (highest priority over issue, push and request in that cycle):
  - head = tail = count = 0; pc = flush_pc.
  - drop = the number of returns still owed: outstanding minus any return arriving this cycle.
  - No request is made in the flush cycle; requests resume the next cycle at flush_pc.
- While drop > 0:
  - Each imem_valid decrements drop and its data is discarded (not pushed and not checked as an end marker).
  - outstanding still decrements on each such return.
- Full: count=DEPTH with outstanding=0 means imem_req=0; fetch resumes the cycle after any issue.
- Reset asserted mid-operation:
  - Immediate return to the reset values.
  - Returns still in flight from before reset are the memory's responsibility; the memory is reset by the same n_rst.

Test Plan:
- Reset, memory at latency 1 holding words at addr 0..3 = 0x00100093, 0x00200113, 0x00300193, 0x00000000, freeze1=freeze2=1 -> imem_addr 0,1,2,3 requested; count settles at 3; HALT; instruction0=0x00100093, instruction1=0x00200113.
- From the previous state, freeze1=0, freeze2=0 for one cycle -> count=1; instruction0=0x00300193, instruction1=NOP. Next cycle, freeze1=0 -> count=0, nothing_filled=1, both outputs NOP.
- Memory of 20 non-zero words, freeze1=1 held -> count reaches 8 and imem_req stays 0. Release freeze1=0 with freeze2=1 for one cycle -> count=7, and a new request is issued the following cycle.
- Memory at latency 3; assert flush with flush_pc=0x040 while 2 requests are outstanding -> the 2 stale returns are discarded; the first pushed word is mem[0x040]; count never exceeds the legal value.
- Queue at count=1 with freeze1=0, freeze2=0 and a return in the same cycle -> the single entry retires, the new word is pushed, and count=1 with the new word at instruction0.
- Assert n_rst low mid-fetch with count=5 -> count=0, imem_req=0, pc restarts at RESET_PC after release.

Source files
------------

// File: rtl/dual_fetch_queue.sv
// Sequential instruction fetcher feeding a circular issue queue. The queue presents its two
// oldest words, retires up to two per cycle and supports flush/redirect of the fetch stream.
module dual_fetch_queue #(
   parameter int unsigned       DEPTH    = 8,
   parameter int unsigned       ADDR_W   = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [31:0]       NOP      = 32'h00000013
) (
   input  logic                      clk,
   input  logic                      n_rst,
   output logic                      imem_req,
   output logic [ADDR_W-1:0]         imem_addr,
   input  logic                      imem_valid,
   input  logic [31:0]               imem_rdata,
   input  logic                      freeze1,
   input  logic                      freeze2,
   input  logic                      flush,
   input  logic [ADDR_W-1:0]         flush_pc,
   output logic [31:0]               instruction0,
   output logic [31:0]               instruction1,
   output logic                      nothing_filled,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned    PTR_W   = $clog2(DEPTH);
   localparam int unsigned    CNT_W   = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

   typedef enum logic {RUN, HALT} state_t;

   state_t            state;
   logic [31:0]       queue_mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W-1:0]  head_nx1;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  drop;
   logic [CNT_W-1:0]  n_issue;
   logic [ADDR_W-1:0] pc;
   logic              live_ret;
   logic              push;
   logic              end_mark;

   // Requested slots clamped to what is actually in the queue.
   function automatic logic [CNT_W-1:0] issue_count(input logic f1, input logic f2,
                                                    input logic [CNT_W-1:0] avail);
      logic [CNT_W-1:0] want;
      want = f1 ? '0 : (f2 ? CNT_W'(1) : CNT_W'(2));
      return (want > avail) ? avail : want;
   endfunction

   assign n_issue  = issue_count(freeze1, freeze2, cnt);
   // Returns that are neither stale (drop) nor past the end marker (HALT).
   assign live_ret = imem_valid && (drop == '0) && (state == RUN);
   assign push     = live_ret && (imem_rdata != 32'h0);
   assign end_mark = live_ret && (imem_rdata == 32'h0);

   // Credit counts in-flight words so every return is guaranteed a free slot.
   assign imem_req  = n_rst && (state == RUN) && !flush &&
                      (({1'b0, cnt} + {1'b0, outstanding}) < DEPTH_L);
   assign imem_addr = pc;

   assign head_nx1       = head + PTR_W'(1);
   assign count          = cnt;
   assign nothing_filled = (cnt == '0);
   assign instruction0   = (cnt != '0)         ? queue_mem[head]     : NOP;
   assign instruction1   = (cnt >= CNT_W'(2))  ? queue_mem[head_nx1] : NOP;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         head        <= '0;
         tail        <= '0;
         cnt         <= '0;
         outstanding <= '0;
         drop        <= '0;
         pc          <= RESET_PC;
         state       <= RUN;
      end else begin
         outstanding <= outstanding + CNT_W'(imem_req) - CNT_W'(imem_valid);
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            pc    <= flush_pc;
            state <= RUN;
            // Everything still owed by memory belongs to the abandoned stream.
            drop  <= outstanding - CNT_W'(imem_valid);
         end else begin
            head <= head + n_issue[PTR_W-1:0];
            cnt  <= cnt - n_issue + CNT_W'(push);
            if (push)
               tail <= tail + PTR_W'(1);
            if (imem_req)
               pc <= pc + ADDR_W'(1);
            if (imem_valid && (drop != '0))
               drop <= drop - CNT_W'(1);
            if (end_mark)
               state <= HALT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         queue_mem[tail] <= imem_rdata;
   end

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Directed bench for dual_fetch_queue: a cycle table for fetch/halt/issue plus
// hand-written sequences for full, flush, same-cycle issue+push and mid-run reset.
module tb_dual_fetch_queue;

   localparam int          DEPTH  = 8;
   localparam int          ADDR_W = 10;
   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] WA     = 32'h00100093;
   localparam logic [31:0] WB     = 32'h00200113;
   localparam logic [31:0] WC     = 32'h00300193;

   logic              clk;
   logic              n_rst;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_valid;
   logic [31:0]       imem_rdata;
   logic              freeze1;
   logic              freeze2;
   logic              flush;
   logic [ADDR_W-1:0] flush_pc;
   logic [31:0]       instruction0;
   logic [31:0]       instruction1;
   logic              nothing_filled;
   logic [3:0]        count;

   dual_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC('0), .NOP(NOP)) dut (
      .clk(clk), .n_rst(n_rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata), .freeze1(freeze1),
      .freeze2(freeze2), .flush(flush), .flush_pc(flush_pc),
      .instruction0(instruction0), .instruction1(instruction1),
      .nothing_filled(nothing_filled), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: fixed latency, in order, reset together with the DUT.
   typedef struct { int unsigned due; logic [31:0] data; } ret_t;
   logic [31:0] mem [1024];
   ret_t        rq [$];
   int unsigned lat;
   int unsigned cyc;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rq.delete();
         cyc = 0;
         imem_valid <= 1'b0;
         imem_rdata <= '0;
      end else begin
         if (imem_req)
            rq.push_back('{cyc + lat, mem[imem_addr]});
         if (rq.size() > 0 && rq[0].due == cyc + 1) begin
            imem_valid <= 1'b1;
            imem_rdata <= rq[0].data;
            void'(rq.pop_front());
         end else begin
            imem_valid <= 1'b0;
         end
         cyc = cyc + 1;
      end
   end

   int n_pass;
   int n_total;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic do_reset();
      n_rst    = 1'b0;
      freeze1  = 1'b1;
      freeze2  = 1'b1;
      flush    = 1'b0;
      flush_pc = '0;
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      #1;
   endtask

   typedef struct {
      logic              f1;
      logic              f2;
      logic              req;
      logic [ADDR_W-1:0] addr;
      logic [3:0]        cnt;
      logic [31:0]       i0;
      logic [31:0]       i1;
   } vec_t;

   vec_t tv [11];

   initial begin
      int k;
      int maxc;
      n_pass  = 0;
      n_total = 0;
      n_rst   = 1'b0;
      freeze1 = 1'b1;
      freeze2 = 1'b1;
      flush   = 1'b0;
      flush_pc = '0;
      lat     = 1;

      // Fetch 0..3 (end marker at 3, addr 4 already in flight), then drain.
      tv[0]  = '{1'b1, 1'b1, 1'b1, 10'd0, 4'd0, NOP, NOP};
      tv[1]  = '{1'b1, 1'b1, 1'b1, 10'd1, 4'd0, NOP, NOP};
      tv[2]  = '{1'b1, 1'b1, 1'b1, 10'd2, 4'd1, WA,  NOP};
      tv[3]  = '{1'b1, 1'b1, 1'b1, 10'd3, 4'd2, WA,  WB};
      tv[4]  = '{1'b1, 1'b1, 1'b1, 10'd4, 4'd3, WA,  WB};
      tv[5]  = '{1'b1, 1'b1, 1'b0, 10'd0, 4'd3, WA,  WB};
      tv[6]  = '{1'b0, 1'b0, 1'b0, 10'd0, 4'd3, WA,  WB};
      tv[7]  = '{1'b0, 1'b1, 1'b0, 10'd0, 4'd1, WC,  NOP};
      tv[8]  = '{1'b0, 1'b0, 1'b0, 10'd0, 4'd0, NOP, NOP};
      tv[9]  = '{1'b1, 1'b1, 1'b0, 10'd0, 4'd0, NOP, NOP};
      tv[10] = '{1'b1, 1'b1, 1'b0, 10'd0, 4'd0, NOP, NOP};

      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i + 1;
      mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = 32'h0; mem[4] = 32'h00400213;

      // Reset state while n_rst is held low.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",   imem_req,       1'b0);
      chk("rst_count", count,          4'd0);
      chk("rst_i0",    instruction0,   NOP);
      chk("rst_i1",    instruction1,   NOP);
      chk("rst_nf",    nothing_filled, 1'b1);

      do_reset();
      for (int r = 0; r < 11; r++) begin
         freeze1 = tv[r].f1;
         freeze2 = tv[r].f2;
         #1;
         chk($sformatf("tab_req[%0d]", r), imem_req, tv[r].req);
         if (tv[r].req)
            chk($sformatf("tab_addr[%0d]", r), imem_addr, tv[r].addr);
         chk($sformatf("tab_count[%0d]", r), count,          tv[r].cnt);
         chk($sformatf("tab_i0[%0d]", r),    instruction0,   tv[r].i0);
         chk($sformatf("tab_i1[%0d]", r),    instruction1,   tv[r].i1);
         chk($sformatf("tab_nf[%0d]", r),    nothing_filled, tv[r].cnt == 4'd0);
         @(posedge clk);
         #1;
      end

      // Full queue: no request until an issue frees a slot.
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i + 1;
      lat = 1;
      do_reset();
      k = 0;
      while (count != 4'd8 && k < 30) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("full_count", count, 4'd8);
      chk("full_i0", instruction0, mem[0]);
      chk("full_i1", instruction1, mem[1]);
      repeat (3) begin
         chk("full_noreq", imem_req, 1'b0);
         @(posedge clk);
         #1;
      end
      freeze1 = 1'b0; freeze2 = 1'b1;
      @(posedge clk);
      #1 freeze1 = 1'b1;
      #1;
      chk("full_issue_count", count, 4'd7);
      chk("full_resume_req", imem_req, 1'b1);
      chk("full_resume_addr", imem_addr, 10'd8);
      chk("full_issue_i0", instruction0, mem[1]);
      @(posedge clk);
      #1;
      chk("full_credit_noreq", imem_req, 1'b0);
      @(posedge clk);
      #1;
      chk("full_refill_count", count, 4'd8);

      // Flush with two stale requests in flight at latency 3.
      lat = 3;
      do_reset();
      chk("fl_req0", imem_req, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("fl_pre_count", count, 4'd0);
      flush = 1'b1; flush_pc = 10'h040;
      #1;
      chk("fl_flush_noreq", imem_req, 1'b0);
      @(posedge clk);
      #1 flush = 1'b0;
      #1;
      chk("fl_redirect_req", imem_req, 1'b1);
      chk("fl_redirect_addr", imem_addr, 10'h040);
      k = 0;
      while (count == 4'd0 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("fl_first_count", count, 4'd1);
      chk("fl_first_word", instruction0, mem[10'h040]);
      @(posedge clk);
      #1;
      chk("fl_second_word", instruction1, mem[10'h041]);
      maxc = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (int'(count) > maxc) maxc = int'(count);
      end
      chk("fl_max_count", maxc, 8);
      chk("fl_head_kept", instruction0, mem[10'h040]);

      // count=1, issue two while a word returns in the same cycle.
      lat = 1;
      do_reset();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("sc_pre_count", count, 4'd1);
      chk("sc_ret_pending", imem_valid, 1'b1);
      freeze1 = 1'b0; freeze2 = 1'b0;
      @(posedge clk);
      #1 freeze1 = 1'b1; freeze2 = 1'b1;
      #1;
      chk("sc_count", count, 4'd1);
      chk("sc_i0", instruction0, mem[1]);
      chk("sc_i1", instruction1, NOP);

      // Asynchronous reset in the middle of fetching.
      do_reset();
      repeat (6) @(posedge clk);
      #1;
      chk("mr_pre_count", count, 4'd5);
      #2 n_rst = 1'b0;
      #1;
      chk("mr_count", count, 4'd0);
      chk("mr_req", imem_req, 1'b0);
      chk("mr_i0", instruction0, NOP);
      chk("mr_nf", nothing_filled, 1'b1);
      @(posedge clk);
      #1 n_rst = 1'b1;
      #1;
      chk("mr_restart_req", imem_req, 1'b1);
      chk("mr_restart_addr", imem_addr, 10'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("mr_refetch_count", count, 4'd1);
      chk("mr_refetch_i0", instruction0, mem[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
